// File: rtl/count_seq_pkg.sv
// Shared types and helpers for the cascaded BCD count sequencer.
package count_seq_pkg;

    localparam int unsigned DIGIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    typedef struct packed {
        logic load;
        logic stop;
        logic start;
        logic step;
    } cmd_t;

    function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] v,
                                                       input logic [DIGIT_W-1:0] max_d);
        return (v > max_d) ? max_d : v;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the BCD chain: up/down count with wrap, clamped preload,
// and combinational carry/borrow out (en & at boundary).
module bcd_digit
    import count_seq_pkg::*;
#(
    parameter int unsigned MAX_DIGIT = 9
) (
    input  logic               ClkRedu,
    input  logic               reset,
    input  logic               en_i,
    input  logic               up_dn_i,
    input  logic               ld_i,
    input  logic [DIGIT_W-1:0] ld_val_i,
    output logic [DIGIT_W-1:0] digit_o,
    output logic               cy_c_o
);

    localparam logic [DIGIT_W-1:0] MAX_V = DIGIT_W'(MAX_DIGIT);

    logic [DIGIT_W-1:0] digit_q, digit_d;
    logic               at_bound;

    always_comb begin
        at_bound = up_dn_i ? (digit_q == MAX_V) : (digit_q == '0);
        cy_c_o   = en_i & at_bound;
        digit_d  = digit_q;
        if (ld_i) begin
            digit_d = clamp_digit(ld_val_i, MAX_V);
        end else if (en_i) begin
            if (at_bound) begin
                digit_d = up_dn_i ? '0 : MAX_V;
            end else begin
                digit_d = up_dn_i ? (digit_q + DIGIT_W'(1)) : (digit_q - DIGIT_W'(1));
            end
        end
    end

    always_ff @(posedge ClkRedu or posedge reset) begin
        if (reset) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o = digit_q;

endmodule

// File: rtl/count_sequencer.sv
// Run/pause/step/load controller driving a chain of DIGITS BCD decades.
// Optional COUNT_SEQ_SYNC_EN: synchronize + edge-detect the command inputs.
module count_sequencer
    import count_seq_pkg::*;
#(
    parameter int unsigned DIGITS    = 2,
    parameter int unsigned MAX_DIGIT = 9
) (
    input  logic                      ClkRedu,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      step,
    input  logic                      up_dn,
    input  logic                      auto_stop,
    input  logic                      load,
    input  logic [DIGIT_W*DIGITS-1:0] load_val,
    output logic [DIGIT_W*DIGITS-1:0] count,
    output logic [1:0]                state_o,
    output logic                      running,
    output logic                      tc,
    output logic                      wrap
);

    localparam int unsigned        CNT_W = DIGIT_W * DIGITS;
    localparam logic [DIGIT_W-1:0] MAX_V = DIGIT_W'(MAX_DIGIT);

    cmd_t              cmd;
    state_t            state_q, state_d;
    logic              running_q, running_d;
    logic              wrap_q;
    logic              adv, ld, adv_ok;
    logic [CNT_W-1:0]  ld_vec;
    logic [DIGITS-1:0] en, cy;
    logic              all_max, all_zero;

`ifdef COUNT_SEQ_SYNC_EN
    // Two-flop synchronizer, third flop for rising-edge detect: one command per press.
    cmd_t s1_q, s2_q, s3_q;

    always_ff @(posedge ClkRedu or posedge reset) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= '{load: load, stop: stop, start: start, step: step};
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign cmd = cmd_t'(s2_q & ~s3_q);
`else
    assign cmd = '{load: load, stop: stop, start: start, step: step};
`endif

    // Terminal count on the live count and direction.
    always_comb begin
        all_max  = 1'b1;
        all_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (count[i*DIGIT_W +: DIGIT_W] != MAX_V) all_max  = 1'b0;
            if (count[i*DIGIT_W +: DIGIT_W] != '0)    all_zero = 1'b0;
        end
    end

    assign tc     = up_dn ? all_max : all_zero;
    assign adv_ok = ~(tc & auto_stop);

    always_ff @(posedge ClkRedu or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= running_d;
            wrap_q    <= cy[DIGITS-1];
        end
    end

    // Next state and datapath controls; in each state only the commands that
    // matter there compete, in load > stop > start > step order.
    always_comb begin
        state_d = state_q;
        adv     = 1'b0;
        ld      = 1'b0;
        ld_vec  = load_val;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd.load) begin
                    ld = 1'b1;
                end else if (cmd.stop) begin
                    state_d = ST_IDLE;
                end else if (cmd.start) begin
                    state_d = ST_RUN;
                end else if (cmd.step) begin
                    adv = adv_ok;
                end
            end
            ST_RUN: begin
                if (cmd.stop) begin
                    state_d = ST_PAUSE;
                end else if (!adv_ok) begin
                    state_d = ST_DONE;
                end else begin
                    adv = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (cmd.load) begin
                    ld = 1'b1;
                end else if (cmd.stop) begin
                    ld      = 1'b1;
                    ld_vec  = '0;
                    state_d = ST_IDLE;
                end else if (cmd.start) begin
                    state_d = ST_RUN;
                end else if (cmd.step) begin
                    adv = adv_ok;
                end
            end
            ST_DONE: begin
                if (cmd.load) begin
                    ld = 1'b1;
                end else if (cmd.stop) begin
                    state_d = ST_IDLE;
                end else if (cmd.start) begin
                    ld      = 1'b1;
                    ld_vec  = up_dn ? '0 : {DIGITS{MAX_V}};
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        running_d = (state_d == ST_RUN);
    end

    // Carry/borrow ripples from digit 0 upward; the last carry marks a full wrap.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        if (g == 0) begin : g_first
            assign en[g] = adv;
        end else begin : g_next
            assign en[g] = cy[g-1];
        end

        bcd_digit #(
            .MAX_DIGIT(MAX_DIGIT)
        ) u_digit (
            .ClkRedu (ClkRedu),
            .reset   (reset),
            .en_i    (en[g]),
            .up_dn_i (up_dn),
            .ld_i    (ld),
            .ld_val_i(ld_vec[g*DIGIT_W +: DIGIT_W]),
            .digit_o (count[g*DIGIT_W +: DIGIT_W]),
            .cy_c_o  (cy[g])
        );
    end

    assign state_o = state_q;
    assign running = running_q;
    assign wrap    = wrap_q;

endmodule
